// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM demap sequencer.
package qam_pkg;

  localparam int SHIFT_BITS           = 4;
  localparam int CAL_LEN_LOG2_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAL_ACC   = 3'd1,
    CAL_LATCH = 3'd2,
    LATCH     = 3'd3,
    SHIFT     = 3'd4
  } qam_state_e;

endpackage

// File: rtl/qam_offset_acc.sv
// I/Q calibration accumulators with a shared sample counter.
// The next-state sums are exported so the offsets can be latched alongside the strobe.
module qam_offset_acc #(
  parameter  int CAL_LEN_LOG2 = 4,
  localparam int AW = 8 + CAL_LEN_LOG2,
  localparam int CW = CAL_LEN_LOG2 + 1
) (
  input  logic                 symbol_clock,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 add_i,
  input  logic signed [7:0]    i_sample_i,
  input  logic signed [7:0]    q_sample_i,
  output logic signed [AW-1:0] i_acc_next_o,
  output logic signed [AW-1:0] q_acc_next_o,
  output logic [CW-1:0]        count_o
);

  logic signed [AW-1:0] i_acc_q, i_acc_d;
  logic signed [AW-1:0] q_acc_q, q_acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] i_ext, q_ext;

  assign i_ext = {{CAL_LEN_LOG2{i_sample_i[7]}}, i_sample_i};
  assign q_ext = {{CAL_LEN_LOG2{q_sample_i[7]}}, q_sample_i};

  // A clear that coincides with a sample starts the new run with that sample.
  always_comb begin
    i_acc_d = i_acc_q;
    q_acc_d = q_acc_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      i_acc_d = add_i ? i_ext : '0;
      q_acc_d = add_i ? q_ext : '0;
      cnt_d   = add_i ? CW'(1) : '0;
    end else if (add_i) begin
      i_acc_d = i_acc_q + i_ext;
      q_acc_d = q_acc_q + q_ext;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      i_acc_q <= '0;
      q_acc_q <= '0;
      cnt_q   <= '0;
    end else begin
      i_acc_q <= i_acc_d;
      q_acc_q <= q_acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i_acc_next_o = i_acc_d;
  assign q_acc_next_o = q_acc_d;
  assign count_o      = cnt_q;

endmodule

// File: rtl/qam_demap_sequencer.sv
// Sequencer for symbol latch/shift and I/Q origin-offset calibration.
// Define QAM_SEQ_OVERRUN_EN to record symbols dropped while a symbol is in flight.
module qam_demap_sequencer
  import qam_pkg::*;
#(
  parameter int CAL_LEN_LOG2 = CAL_LEN_LOG2_DEFAULT
) (
  input  logic              symbol_clock,
  input  logic              rst,
  input  logic              en_i,
  input  logic              cal_req_i,
  input  logic              sym_valid_i,
  input  logic signed [7:0] i_in_i,
  input  logic signed [7:0] q_in_i,
  output logic              latch_offset_o,
  output logic signed [7:0] i_offset_o,
  output logic signed [7:0] q_offset_o,
  output logic              latch_reg_o,
  output logic              shift_o,
  output logic              busy_o,
  output logic              cal_done_o,
  output logic              overrun_o,
  output logic [2:0]        state_o
);

  localparam int AW = 8 + CAL_LEN_LOG2;
  localparam int CW = CAL_LEN_LOG2 + 1;
  localparam int BW = $clog2(SHIFT_BITS);

  qam_state_e           state_q;
  logic                 pending_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 latch_offset_q, latch_reg_q, shift_q, busy_q, cal_done_q;
  logic signed [7:0]    i_offset_q, q_offset_q;

  logic                 start_cal, acc_add, cal_last;
  logic signed [AW-1:0] i_acc_next, q_acc_next;
  logic [CW-1:0]        acc_count;

  assign start_cal = (state_q == IDLE) && (cal_req_i || pending_q);
  assign acc_add   = sym_valid_i && (start_cal || (state_q == CAL_ACC));
  assign cal_last  = (state_q == CAL_ACC) && sym_valid_i &&
                     (acc_count == CW'((1 << CAL_LEN_LOG2) - 1));

  qam_offset_acc #(.CAL_LEN_LOG2(CAL_LEN_LOG2)) u_acc (
    .symbol_clock (symbol_clock),
    .rst          (rst),
    .clear_i      (start_cal),
    .add_i        (acc_add),
    .i_sample_i   (i_in_i),
    .q_sample_i   (q_in_i),
    .i_acc_next_o (i_acc_next),
    .q_acc_next_o (q_acc_next),
    .count_o      (acc_count)
  );

  // Strobes are registered against the state being entered, so each one is
  // high exactly while the FSM sits in the matching state.
  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      state_q        <= IDLE;
      pending_q      <= 1'b0;
      bit_cnt_q      <= '0;
      latch_offset_q <= 1'b0;
      latch_reg_q    <= 1'b0;
      shift_q        <= 1'b0;
      busy_q         <= 1'b0;
      cal_done_q     <= 1'b0;
      i_offset_q     <= '0;
      q_offset_q     <= '0;
    end else begin
      latch_offset_q <= 1'b0;
      latch_reg_q    <= 1'b0;
      shift_q        <= 1'b0;
      if (cal_req_i && (state_q != IDLE)) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_cal) begin
            state_q   <= CAL_ACC;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
          end else if (en_i && sym_valid_i) begin
            state_q     <= LATCH;
            latch_reg_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        CAL_ACC: begin
          if (cal_last) begin
            state_q        <= CAL_LATCH;
            latch_offset_q <= 1'b1;
            cal_done_q     <= 1'b1;
            i_offset_q     <= 8'(i_acc_next >>> CAL_LEN_LOG2);
            q_offset_q     <= 8'(q_acc_next >>> CAL_LEN_LOG2);
          end
        end
        CAL_LATCH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        LATCH: begin
          state_q   <= SHIFT;
          bit_cnt_q <= '0;
          shift_q   <= 1'b1;
        end
        SHIFT: begin
          if (bit_cnt_q == BW'(SHIFT_BITS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
            shift_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef QAM_SEQ_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (start_cal) begin
      overrun_q <= 1'b0;
    end else if (en_i && sym_valid_i && ((state_q == LATCH) || (state_q == SHIFT))) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

  assign latch_offset_o = latch_offset_q;
  assign latch_reg_o    = latch_reg_q;
  assign shift_o        = shift_q;
  assign busy_o         = busy_q;
  assign cal_done_o     = cal_done_q;
  assign i_offset_o     = i_offset_q;
  assign q_offset_o     = q_offset_q;
  assign state_o        = state_q;

endmodule

// File: doc/qam_demap_sequencer.md
QAM_DEMAP_SEQUENCER -- requirements
Module: qam_demap_sequencer

Interface
REQ-001 Parameter: CAL_LEN_LOG2, default 4, log2 of the calibration sample count; legal range 1..6.
REQ-002 symbol_clock  in  1  block clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 en  in  1  enable for symbol demap/shift sequencing.
REQ-005 cal_req  in  1  calibration request; a one-cycle pulse is sufficient.
REQ-006 sym_valid  in  1  qualifies I_in/Q_in as a new symbol or calibration sample.
REQ-007 I_in, Q_in  in  8 each  signed samples; read only during calibration.
REQ-008 latch_offset  out  1  one-cycle strobe; I_offset/Q_offset are new.
REQ-009 I_offset, Q_offset  out  8 each  signed origin offsets, registered.
REQ-010 latch_reg  out  1  one-cycle strobe; datapath captures the demapped 4-bit symbol.
REQ-011 shift  out  1  serializer shift enable, high for exactly 4 consecutive cycles per symbol.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 cal_done  out  1  sticky; high after the first completed calibration.
REQ-014 overrun  out  1  sticky symbol-drop flag (see Configuration).

Function
REQ-015 The FSM states SHALL be IDLE, CAL_ACC, CAL_LATCH, LATCH and SHIFT.
REQ-016 IDLE: cal_req or a pending calibration request SHALL go to CAL_ACC; otherwise en&sym_valid SHALL go to LATCH; calibration takes priority when both are present.
REQ-017 CAL_ACC: each sym_valid cycle SHALL add sign-extended I_in/Q_in into (8+CAL_LEN_LOG2)-bit signed accumulators; after 2^CAL_LEN_LOG2 samples, go to CAL_LATCH.
REQ-018 Accumulators and the sample counter SHALL clear on entry to CAL_ACC; accumulator overflow is impossible by width.
REQ-019 CAL_LATCH (one cycle): I_offset/Q_offset SHALL load acc >>> CAL_LEN_LOG2 (arithmetic shift, truncating toward minus infinity); latch_offset=1; cal_done set; go to IDLE.
REQ-020 LATCH (one cycle): latch_reg=1; go to SHIFT with the bit counter at 0.
REQ-021 SHIFT: shift=1 each cycle; after the 4th cycle (counter=3), go to IDLE.
REQ-022 Symbol latency: sym_valid accepted at cycle N -> latch_reg at N+1 -> shift at N+2..N+5; the next symbol is accepted no earlier than N+6.
REQ-023 sym_valid outside IDLE and CAL_ACC SHALL be dropped; no symbol is queued.
REQ-024 cal_req seen outside IDLE SHALL set a pending flag, consumed at the next IDLE; multiple requests collapse to one.
REQ-025 en deasserted mid-symbol SHALL NOT abort LATCH/SHIFT; the symbol completes.
REQ-026 en is ignored during calibration; calibration runs whenever it is requested.
REQ-027 Offsets SHALL hold their values between calibrations.
REQ-028 latch_offset, latch_reg and shift SHALL be mutually exclusive in every cycle.

Reset
REQ-029 rst SHALL force IDLE and zero all outputs, offsets, accumulators, counters, the pending flag, cal_done and overrun, including mid-calibration and mid-shift.

Configuration
REQ-030 With QAM_SEQ_OVERRUN_EN defined, sym_valid&en in LATCH/SHIFT SHALL set overrun, cleared only by rst or on entry to CAL_ACC.
REQ-031 Without QAM_SEQ_OVERRUN_EN, overrun SHALL be constant 0; drop behaviour is unchanged.

Structure
REQ-032 Package qam_pkg SHALL hold the state enum, SHIFT_BITS=4 and CAL_LEN_LOG2_DEFAULT=4.
REQ-033 The two accumulators and the sample counter SHALL form one sub-module, qam_offset_acc, instantiated once with I and Q lanes.

Verification
REQ-034 Reset, then cal_req with 16 samples I=10, Q=-6 -> latch_offset one cycle; I_offset=10, Q_offset=-6; cal_done=1.
REQ-035 Calibration with I alternating 127/-128 over 16 samples -> I_offset=-1 (sum -8, >>>4).
REQ-036 en=1, sym_valid at cycle 0 -> latch_reg at cycle 1, shift at cycles 2-5, busy low at cycle 6; sym_valid at cycle 3 dropped and overrun=1 (macro on) / overrun=0 (macro off).
REQ-037 cal_req at cycle 3 of a shift sequence -> shifts complete, then CAL_ACC entered at the first IDLE cycle.
REQ-038 rst at cycle 2 of a shift sequence -> next cycle all outputs 0, state IDLE; offsets 0.
REQ-039 cal_req and sym_valid in the same IDLE cycle -> CAL_ACC entered, and that sym_valid is counted as calibration sample 1.
